// File: rtl/config_pkg.sv
// Shared fixed-point configuration for the rowwise pipeline: row width, element
// format, reduction selector and the saturating fixed-point adder.
package config_pkg;

  localparam int unsigned D       = 8;
  localparam int unsigned FP_W    = 16;
  localparam int unsigned FP_FRAC = 8;
  localparam int unsigned IDX_W   = $clog2(D);

  typedef logic signed [FP_W-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0]   vector_t;

  typedef enum logic {
    RED_SUM,
    RED_MAX
  } reduce_op_t;

  localparam fixed_point_t FIXED_POINT_MIN = {1'b1, {(FP_W-1){1'b0}}};
  localparam fixed_point_t FIXED_POINT_MAX = {1'b0, {(FP_W-1){1'b1}}};

  // Saturating add: overflow is detected when the two top bits of the
  // one-bit-wider sum disagree.
  function automatic fixed_point_t fixed_point_add(input fixed_point_t a,
                                                   input fixed_point_t b);
    logic signed [FP_W:0] s;
    s = {a[FP_W-1], a} + {b[FP_W-1], b};
    if (s[FP_W] != s[FP_W-1]) begin
      return s[FP_W] ? FIXED_POINT_MIN : FIXED_POINT_MAX;
    end
    return s[FP_W-1:0];
  endfunction

endpackage

// File: rtl/rowwise_reduce.sv
// Serial row reducer: captures one D-element row, folds it element by element
// into a SUM or a signed MAX (with argmax), then holds the result until taken.
module rowwise_reduce
  import config_pkg::*;
#(
  parameter reduce_op_t reduction = RED_SUM
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  vector_t            vector_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output fixed_point_t       scalar_o,
  output logic [IDX_W-1:0]   index_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam fixed_point_t ACC_INIT = (reduction == RED_MAX) ? FIXED_POINT_MIN : '0;

  state_t             r_state;
  state_t             w_state_nx;
  vector_t            r_vec;
  fixed_point_t       r_acc;
  fixed_point_t       w_acc_nx;
  fixed_point_t       w_elem;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nx;
  logic               w_accept;
  logic               w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid_i;
  assign w_last   = (r_cnt == IDX_W'(D - 1));
  assign w_elem   = r_vec[r_cnt];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid_i)  w_state_nx = S_ACCUM;
      S_ACCUM: if (w_last)      w_state_nx = S_DONE;
      S_DONE:  if (out_ready_i) w_state_nx = S_IDLE;
      default:                  w_state_nx = S_IDLE;
    endcase
  end

  generate
    if (reduction == RED_MAX) begin : g_max
      // Strict compare keeps the earliest index on ties.
      always_comb begin
        w_acc_nx = r_acc;
        w_idx_nx = r_idx;
        if (w_elem > r_acc) begin
          w_acc_nx = w_elem;
          w_idx_nx = r_cnt;
        end
      end
    end else begin : g_sum
      always_comb begin
        w_acc_nx = fixed_point_add(r_acc, w_elem);
        w_idx_nx = r_idx;
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vec <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_vec <= vector_i;
      r_acc <= ACC_INIT;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_state == S_ACCUM) begin
      r_acc <= w_acc_nx;
      r_idx <= w_idx_nx;
      if (!w_last) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign scalar_o    = r_acc;
  assign index_o     = (reduction == RED_MAX) ? r_idx : '0;

endmodule

// File: tb/tb_rowwise_reduce.sv
// Bench for rowwise_reduce: a SUM and a MAX instance driven in lockstep from a
// vector table, random rows checked against a reference model, and corner sequences.
module tb_rowwise_reduce;
  import config_pkg::*;

  logic             clk;
  logic             rst_n;
  vector_t          vec_in;
  logic             in_valid;
  logic             out_ready;
  logic             rdy_s, vld_s, rdy_m, vld_m;
  fixed_point_t     sc_s, sc_m;
  logic [IDX_W-1:0] ix_s, ix_m;

  int n_tests = 0;
  int n_fail  = 0;

  rowwise_reduce #(.reduction(RED_SUM)) u_sum (
    .clk_i(clk), .rst_ni(rst_n), .vector_i(vec_in), .in_valid_i(in_valid),
    .in_ready_o(rdy_s), .scalar_o(sc_s), .index_o(ix_s),
    .out_valid_o(vld_s), .out_ready_i(out_ready)
  );

  rowwise_reduce #(.reduction(RED_MAX)) u_max (
    .clk_i(clk), .rst_ni(rst_n), .vector_i(vec_in), .in_valid_i(in_valid),
    .in_ready_o(rdy_m), .scalar_o(sc_m), .index_o(ix_m),
    .out_valid_o(vld_m), .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string        name;
    vector_t      vec;
    fixed_point_t exp_sum;
    fixed_point_t exp_max;
    int           exp_idx;
  } vec_rec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vector_t splat(input fixed_point_t x);
    vector_t v;
    for (int i = 0; i < int'(D); i++) v[i] = x;
    return v;
  endfunction

  // Reference: saturating running sum; first occurrence of the largest element.
  task automatic model(input vector_t v, output fixed_point_t s, output fixed_point_t m,
                       output int ix);
    int acc;
    int best;
    acc  = 0;
    best = int'(v[0]);
    ix   = 0;
    for (int i = 0; i < int'(D); i++) begin
      acc = acc + int'(v[i]);
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      if (int'(v[i]) > best) begin
        best = int'(v[i]);
        ix   = i;
      end
    end
    s = fixed_point_t'(acc);
    m = fixed_point_t'(best);
  endtask

  task automatic start_and_wait(input vector_t v, output int lat, output bit ok);
    @(negedge clk);
    check("in_ready_idle_sum", rdy_s, 1);
    check("in_ready_idle_max", rdy_m, 1);
    vec_in   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vec_in   = ~v;
    lat = 0;
    ok  = 1'b0;
    @(negedge clk);
    check("in_ready_accum", rdy_s, 0);
    while (lat < 4 * int'(D)) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (vld_s && vld_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_release_valid", vld_s | vld_m, 0);
    check("idle_after_release_ready", rdy_s & rdy_m, 1);
  endtask

  task automatic do_row(input string name, input vector_t v, input fixed_point_t es,
                        input fixed_point_t em, input int ei);
    int lat;
    bit ok;
    start_and_wait(v, lat, ok);
    if (ok) begin
      check({name, "_latency"}, lat, D);
      check({name, "_sum"}, sc_s, es);
      check({name, "_sum_index"}, ix_s, 0);
      check({name, "_max"}, sc_m, em);
      check({name, "_argmax"}, ix_m, ei);
      finish_out();
    end
  endtask

  vec_rec_t     tbl[6];
  vector_t      v;
  fixed_point_t es, em;
  int           ei;
  int           lat;
  bit           ok;
  fixed_point_t hold_s, hold_m;
  logic [IDX_W-1:0] hold_i;

  initial begin
    tbl[0].name = "ones";      tbl[0].vec = splat(16'sh0100);
    tbl[0].exp_sum = 16'sh0800; tbl[0].exp_max = 16'sh0100; tbl[0].exp_idx = 0;

    v = splat('0);
    v[0] = 16'shFD00; v[2] = 16'sh0500; v[7] = 16'sh0500;
    tbl[1].name = "tie";       tbl[1].vec = v;
    tbl[1].exp_sum = 16'sh0700; tbl[1].exp_max = 16'sh0500; tbl[1].exp_idx = 2;

    tbl[2].name = "neg2";      tbl[2].vec = splat(16'shFE00);
    tbl[2].exp_sum = 16'shF000; tbl[2].exp_max = 16'shFE00; tbl[2].exp_idx = 0;

    tbl[3].name = "sat_pos";   tbl[3].vec = splat(16'sh7000);
    tbl[3].exp_sum = 16'sh7FFF; tbl[3].exp_max = 16'sh7000; tbl[3].exp_idx = 0;

    tbl[4].name = "sat_neg";   tbl[4].vec = splat(16'sh8000);
    tbl[4].exp_sum = 16'sh8000; tbl[4].exp_max = 16'sh8000; tbl[4].exp_idx = 0;

    for (int i = 0; i < int'(D); i++) v[i] = fixed_point_t'((i - 4) * 256);
    tbl[5].name = "ramp";      tbl[5].vec = v;
    tbl[5].exp_sum = 16'shFC00; tbl[5].exp_max = 16'sh0300; tbl[5].exp_idx = 7;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; vec_in = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", vld_s | vld_m, 0);
    check("reset_ready", rdy_s & rdy_m, 1);
    check("reset_scalar_max", sc_m, 0);
    check("reset_index_max", ix_m, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_scalar_sum", sc_s, 0);

    for (int t = 0; t < 6; t++) begin
      do_row(tbl[t].name, tbl[t].vec, tbl[t].exp_sum, tbl[t].exp_max, tbl[t].exp_idx);
    end

    // Backpressure: hold the result for 10 cycles while poking in_valid.
    v = splat(16'sh0180);
    v[5] = 16'sh0400;
    model(v, es, em, ei);
    start_and_wait(v, lat, ok);
    if (ok) begin
      hold_s = sc_s; hold_m = sc_m; hold_i = ix_m;
      check("bp_sum", hold_s, es);
      check("bp_max", hold_m, em);
      check("bp_argmax", hold_i, ei);
      for (int k = 0; k < 10; k++) begin
        vec_in   = splat(16'sh7F00);
        in_valid = (k % 2 == 0);
        @(posedge clk);
        @(negedge clk);
        check("bp_valid_held", vld_s & vld_m, 1);
        check("bp_ready_low", rdy_s | rdy_m, 0);
        check("bp_sum_stable", sc_s, hold_s);
        check("bp_max_stable", sc_m, hold_m);
        check("bp_idx_stable", ix_m, hold_i);
      end
      in_valid = 1'b0;
      finish_out();
      @(negedge clk);
      check("bp_no_stray_accept", rdy_s & rdy_m, 1);
    end
    v = splat(16'shFF00);
    v[3] = 16'sh0200;
    model(v, es, em, ei);
    do_row("after_bp", v, es, em, ei);

    // Reset mid-reduction at counter = D/2, then a fresh row.
    @(negedge clk);
    vec_in   = splat(16'sh0300);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (D / 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", vld_s | vld_m, 0);
    check("midrst_ready", rdy_s & rdy_m, 1);
    check("midrst_scalar_sum", sc_s, 0);
    check("midrst_scalar_max", sc_m, 0);
    check("midrst_index_max", ix_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = splat(16'sh0040);
    v[1] = 16'shFFC0;
    model(v, es, em, ei);
    do_row("fresh_after_rst", v, es, em, ei);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'(D); i++) begin
        if ($urandom_range(0, 3) == 0) v[i] = fixed_point_t'($urandom);
        else v[i] = fixed_point_t'((int'($urandom_range(0, 4)) - 2) * 256);
      end
      model(v, es, em, ei);
      do_row("random", v, es, em, ei);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
